hazard_stall_ctrl: RTL

//   Pipeline hazard/stall controller: the producer of the stall inputs consumed by the FlipFlop PC and stage registers.

---
 rtl/hazard_stall_ctrl_pkg.sv | 55 +++++
 rtl/hazard_stall_ctrl_cmp.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ============================================================================
// hazard_stall_ctrl_pkg
//   Shared types for the pipeline hazard/stall controller and the hazard
//   comparator: state encodings, output bundle and the state decode.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_stall_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_LOAD_USE  = 2'd1,
    HZ_MEM_WAIT  = 2'd2,
    HZ_FLUSH     = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_fd;
    logic stall_dx;
    logic stall_xm;
    logic flush_fd;
    logic flush_dx;
  } hz_ctrl_t;

  // Moore decode: every control output is a pure function of the state.
  function automatic hz_ctrl_t hz_decode(input hz_state_e st);
    hz_ctrl_t c;
    c = '0;
    case (st)
      HZ_LOAD_USE: begin
        c.stall_pc = 1'b1;
        c.stall_fd = 1'b1;
      end
      HZ_MEM_WAIT: begin
        c.stall_pc = 1'b1;
        c.stall_fd = 1'b1;
        c.stall_dx = 1'b1;
        c.stall_xm = 1'b1;
      end
      HZ_FLUSH: begin
        c.flush_fd = 1'b1;
        c.flush_dx = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_cmp.sv
// ============================================================================
// hazard_cmp
//   Load-use hazard detector between the decode and execute stages.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_cmp
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             uses_rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             is_load_i,
  output logic             lu_hz_o
);

  logic w_rd_nz;
  logic w_hit_rs1;
  logic w_hit_rs2;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_rd_nz   = (rd_i != '0);
  assign w_hit_rs1 = (rd_i == rs1_i);
  assign w_hit_rs2 = uses_rs2_i & (rd_i == rs2_i);
  assign lu_hz_o   = is_load_i & w_rd_nz & (w_hit_rs1 | w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl
//   Generates registered stall/flush controls for the PC and stage registers
//   from load-use hazards, multi-cycle dmem accesses and execute redirects.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             stall_xm,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  hz_ctrl_t          ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic w_lu_hz;
  logic w_mem_stall;
  logic w_wait_exit;

  hazard_cmp u_cmp (
    .rs1_i      (id_rs1),
    .rs2_i      (id_rs2),
    .uses_rs2_i (id_uses_rs2),
    .rd_i       (ex_rd),
    .is_load_i  (ex_is_load),
    .lu_hz_o    (w_lu_hz)
  );

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_wait_exit = mem_ready | (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    // Redirects seen while a stall is in progress are remembered until a
    // FLUSH cycle can be issued.
    pend_d  = pend_q | ex_redirect;

    case (state_q)
      HZ_RUN: begin
        if (w_mem_stall) begin
          state_d = HZ_MEM_WAIT;
          wait_d  = '0;
        end else if (w_lu_hz) begin
          state_d = HZ_LOAD_USE;
        end else if (pend_d) begin
          state_d = HZ_FLUSH;
          pend_d  = 1'b0;
        end
      end
      HZ_LOAD_USE: begin
        if (pend_d) begin
          state_d = HZ_FLUSH;
          pend_d  = 1'b0;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_MEM_WAIT: begin
        if (w_wait_exit) begin
          wait_d = '0;
          err_d  = ~mem_ready;
          if (pend_d) begin
            state_d = HZ_FLUSH;
            pend_d  = 1'b0;
          end else begin
            state_d = HZ_RUN;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HZ_FLUSH: begin
        state_d = HZ_RUN;
      end
      default: begin
        state_d = HZ_RUN;
        wait_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign ctrl_d = hz_decode(state_d);

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_q.stall_pc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HZ_RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_pc     = ctrl_q.stall_pc;
  assign stall_fd     = ctrl_q.stall_fd;
  assign stall_dx     = ctrl_q.stall_dx;
  assign stall_xm     = ctrl_q.stall_xm;
  assign flush_fd     = ctrl_q.flush_fd;
  assign flush_dx     = ctrl_q.flush_dx;
  assign err_timeout  = err_q;
  assign stall_cycles = cnt_q;

endmodule

`default_nettype wire
